uart_program_loader: RTL and testbench

Receive-side controller that fills the CPU's 32×8 instruction memory over the serial RX line. On a Load pulse it holds the CPU in reset, deserialises 8N1 UART frames at a fixed divisor, takes the first byte as a length count, and writes the following bytes into consecutive memory addresses starting at 0. It then releases the CPU to run from PC 0. It sits between the board RX pin and the instruction-memory write port, alongside the PC-indexed read path.

---
 rtl/uart_program_loader.sv | 189 ++++++++++++++++++
 tb/tb_uart_program_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Serial program loader: receives 8N1 frames on rx, takes the first byte as a length
// and writes the following bytes to instruction memory while holding the CPU in reset.
module uart_program_loader #(
  parameter int unsigned UBRR  = 10415,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  input  logic          load,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          fe,
  output logic          cpu_rst
);

  localparam int unsigned CntW = $clog2(UBRR);
  localparam logic [CntW-1:0] HalfBit = CntW'(UBRR / 2);
  localparam logic [CntW-1:0] FullBit = CntW'(UBRR - 1);
  localparam logic [AW:0]     DepthW  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StHunt, StStart, StData, StStop, StWrite} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW:0]     idx_q, idx_d;
  logic [AW:0]     len_q, len_d;
  logic            have_len_q, have_len_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      have_len_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fe_q       <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      have_len_q <= have_len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fe_q       <= fe_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    len_d      = len_q;
    have_len_d = have_len_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fe_d       = fe_q;
    cpu_rst_d  = cpu_rst_q;

    if (!cnt_zero && (state_q == StStart || state_q == StData || state_q == StStop)) begin
      cnt_d = cnt_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (load) begin
          done_d     = 1'b0;
          fe_d       = 1'b0;
          busy_d     = 1'b1;
          cpu_rst_d  = 1'b1;
          idx_d      = '0;
          len_d      = '0;
          have_len_d = 1'b0;
          state_d    = StHunt;
        end
      end
      StHunt: begin
        if (!rx_sync_q) begin
          cnt_d   = HalfBit;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_zero) begin
          if (rx_sync_q) begin
            state_d = StHunt;
          end else begin
            cnt_d   = FullBit;
            bit_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (cnt_zero) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FullBit;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (cnt_zero) begin
          if (!rx_sync_q) begin
            fe_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            // Write is issued here so wr_en appears one cycle after the stop sample.
            if (have_len_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = idx_q[AW-1:0];
              wr_data_d = shift_q;
              idx_d     = idx_q + (AW+1)'(1);
            end else begin
              have_len_d = 1'b1;
              len_d      = (shift_q == 8'd0 || 32'(shift_q) > DEPTH) ? DepthW : shift_q[AW:0];
            end
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (have_len_q && idx_q == len_q) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cpu_rst_d = 1'b0;
          state_d   = StIdle;
        end else begin
          state_d = StHunt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign fe      = fe_q;
  assign cpu_rst = cpu_rst_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table of load sessions plus hand-written corner cases,
// checked against a byte-level model of the loader.
module tb_uart_program_loader;

  localparam int unsigned UBRR  = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          load;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy, done, fe, cpu_rst;

  uart_program_loader #(.UBRR(UBRR), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .load    (load),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .fe      (fe),
    .cpu_rst (cpu_rst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [AW-1:0] got_addr[$];
  logic [7:0]    got_data[$];
  int last_wr_cyc, done_rise_cyc, cpu_fall_cyc;
  logic done_prev = 1'b0;
  logic cpu_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (done === 1'b1 && !done_prev) done_rise_cyc = cyc;
    if (cpu_rst === 1'b0 && cpu_prev) cpu_fall_cyc = cyc;
    done_prev = (done === 1'b1);
    cpu_prev  = (cpu_rst === 1'b1);
  end

  typedef struct {
    logic [7:0] len;
    int         ndata;
    int         bad_idx;
    bit         glitch;
    int         exp_w;
    bit         exp_done;
    bit         exp_fe;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(UBRR);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // Expected outcome of a session from the byte stream alone.
  function automatic void model(input logic [7:0] len, input int ndata, input int bad,
                                output int w, output bit d, output bit f);
    int n;
    int sent;
    n = (len == 0 || int'(len) > int'(DEPTH)) ? int'(DEPTH) : int'(len);
    f = (bad >= 0);
    sent = f ? bad - 1 : ndata;
    if (sent < 0) sent = 0;
    w = (sent < n) ? sent : n;
    d = !f && (sent >= n);
  endfunction

  task automatic run_session(input string name, input logic [7:0] b[$], input int bad_idx,
                             input bit glitch, input int exp_w, input bit exp_done,
                             input bit exp_fe);
    int n;
    got_addr.delete();
    got_data.delete();
    last_wr_cyc = -1;
    done_rise_cyc = -1;
    cpu_fall_cyc = -1;
    do_load();
    check({name, "_busy_after_load"}, busy, 1);
    check({name, "_cpurst_after_load"}, cpu_rst, 1);
    check({name, "_fe_after_load"}, fe, 0);
    check({name, "_done_after_load"}, done, 0);
    if (glitch) begin
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(2 * UBRR);
    end
    for (int i = 0; i < b.size(); i++) begin
      if (i == bad_idx) begin
        send_byte(b[i], 1'b0);
        break;
      end
      send_byte(b[i], 1'b1);
    end
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    check({name, "_busy_end"}, busy, 0);
    check({name, "_nwrites"}, got_addr.size(), exp_w);
    for (int i = 0; i < exp_w && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), got_addr[i], i);
      check($sformatf("%s_data%0d", name, i), got_data[i], b[i+1]);
    end
    check({name, "_done"}, done, exp_done);
    check({name, "_fe"}, fe, exp_fe);
    check({name, "_cpurst"}, cpu_rst, !exp_done);
    if (exp_done) begin
      check({name, "_done_timing"}, done_rise_cyc, last_wr_cyc + 1);
      check({name, "_cpurst_fall_timing"}, cpu_fall_cyc, done_rise_cyc);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int w;
    bit d, f;

    vecs[0] = '{len: 8'd3,  ndata: 3,  bad_idx: -1, glitch: 0, exp_w: 3,  exp_done: 1, exp_fe: 0};
    vecs[1] = '{len: 8'd0,  ndata: 32, bad_idx: -1, glitch: 0, exp_w: 32, exp_done: 1, exp_fe: 0};
    vecs[2] = '{len: 8'd40, ndata: 32, bad_idx: -1, glitch: 0, exp_w: 32, exp_done: 1, exp_fe: 0};
    vecs[3] = '{len: 8'd1,  ndata: 1,  bad_idx: -1, glitch: 1, exp_w: 1,  exp_done: 1, exp_fe: 0};
    vecs[4] = '{len: 8'd2,  ndata: 1,  bad_idx: 1,  glitch: 0, exp_w: 0,  exp_done: 0, exp_fe: 1};
    vecs[5] = '{len: 8'd5,  ndata: 4,  bad_idx: 3,  glitch: 0, exp_w: 2,  exp_done: 0, exp_fe: 1};
    vecs[6] = '{len: 8'd1,  ndata: 0,  bad_idx: 0,  glitch: 0, exp_w: 0,  exp_done: 0, exp_fe: 1};
    vecs[7] = '{len: 8'd32, ndata: 32, bad_idx: -1, glitch: 0, exp_w: 32, exp_done: 1, exp_fe: 0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].len     = 8'($urandom_range(1, 12));
      vecs[i].ndata   = int'(vecs[i].len);
      vecs[i].bad_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, vecs[i].len)) : -1;
      vecs[i].glitch  = 1'($urandom_range(0, 1));
      model(vecs[i].len, vecs[i].ndata, vecs[i].bad_idx, w, d, f);
      vecs[i].exp_w    = w;
      vecs[i].exp_done = d;
      vecs[i].exp_fe   = f;
    end

    // Reset and idle line.
    rst_n = 1'b0;
    rx    = 1'b1;
    load  = 1'b0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_cpurst", cpu_rst, 0);
    check("rst_wr_en", wr_en, 0);
    rst_n = 1'b1;
    got_addr.delete();
    tick(1000);
    check("idle_nwrites", got_addr.size(), 0);
    check("idle_outputs", {wr_en, wr_addr, wr_data, busy, done, fe, cpu_rst}, 0);

    // Reference session from the plan with fixed bytes.
    q = '{8'h03, 8'hA0, 8'h41, 8'h62};
    run_session("plan_basic", q, -1, 1'b0, 3, 1'b1, 1'b0);

    // Address equals data over the full depth.
    q = '{8'h00};
    for (int i = 0; i < 32; i++) q.push_back(8'(i));
    run_session("full_depth", q, -1, 1'b0, 32, 1'b1, 1'b0);

    for (int v = 0; v < 12; v++) begin
      q = '{vecs[v].len};
      for (int i = 0; i < vecs[v].ndata; i++) q.push_back(8'($urandom));
      model(vecs[v].len, vecs[v].ndata, vecs[v].bad_idx, w, d, f);
      check($sformatf("vec%0d_model_w", v), w, vecs[v].exp_w);
      run_session($sformatf("vec%0d", v), q, vecs[v].bad_idx, vecs[v].glitch,
                  vecs[v].exp_w, vecs[v].exp_done, vecs[v].exp_fe);
    end

    // Reset mid-way through a data frame, after one write has landed.
    got_addr.delete();
    do_load();
    send_byte(8'h02, 1'b1);
    send_byte(8'hC3, 1'b1);
    check("midrst_first_write", wr_data, 8'hC3);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {wr_en, wr_addr, wr_data, busy, done, fe, cpu_rst}, 0);
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(UBRR * 6);
    check("midrst_nwrites", got_addr.size(), 1);
    q = '{8'h01, 8'h99};
    run_session("after_rst", q, -1, 1'b0, 1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
